// File: rtl/input_conditioner_if.sv
// Pin-side bundle of input_conditioner: raw pins in, conditioned levels/events out.
// The master drives raw_in (board pins); the slave is the conditioner itself.
interface input_conditioner_if;
  logic [6:0] raw_in;
  logic [6:0] level_out;
  logic [6:0] press_out;
  logic [6:0] release_out;
  logic [6:0] busy_out;

  modport master (
    output raw_in,
    input  level_out,
    input  press_out,
    input  release_out,
    input  busy_out
  );

  modport slave (
    input  raw_in,
    output level_out,
    output press_out,
    output release_out,
    output busy_out
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel sync, polarity normalise and debounce of 7 board inputs with press/release events.
// Optional auto-repeat of press events on masked channels: define INPUT_COND_AUTOREPEAT_EN.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [6:0]  INVERT_MASK     = 7'b0001111,
  parameter logic [6:0]  REPEAT_MASK     = 7'b0001111,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  input_conditioner_if.slave bus
);

  localparam int unsigned   NCH      = 7;
  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] press_q;
  logic [NCH-1:0] release_q;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] rpt_fire;
  logic [NCH-1:0] busy;
  logic [CW-1:0]  cnt   [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  // A mismatch against stable must persist for DEBOUNCE_CYCLES edges; any
  // return to stable drops the partial count.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      accept[i] = 1'b0;
      cnt_d[i]  = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW          = $clog2(RMAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic {
    RPT_DELAY,
    RPT_PERIOD
  } rpt_phase_t;

  rpt_phase_t     phase   [NCH];
  rpt_phase_t     phase_d [NCH];
  logic [RW-1:0]  rc      [NCH];
  logic [RW-1:0]  rc_d    [NCH];

  // rc is 0 on the press edge, so a match on *_LAST fires exactly DELAY/PERIOD
  // cycles after the previous pulse; a release edge suppresses a coincident repeat.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      rpt_fire[i] = 1'b0;
      rc_d[i]     = '0;
      phase_d[i]  = RPT_DELAY;
      if (REPEAT_MASK[i] && stable[i]) begin
        if (rc[i] == ((phase[i] == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_fire[i] = ~accept[i];
          phase_d[i]  = RPT_PERIOD;
        end else begin
          rc_d[i]    = rc[i] + 1'b1;
          phase_d[i] = phase[i];
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        rc[i]    <= '0;
        phase[i] <= RPT_DELAY;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        rc[i]    <= rc_d[i];
        phase[i] <= phase_d[i];
      end
    end
  end
`else
  always_comb begin
    rpt_fire = '0;
  end
`endif

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= bus.raw_in ^ INVERT_MASK;
      s2        <= s1;
      stable    <= stable ^ accept;
      press_q   <= (accept & s2) | rpt_fire;
      release_q <= accept & ~s2;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  always_comb begin
    bus.level_out   = stable;
    bus.press_out   = press_q;
    bus.release_out = release_q;
    bus.busy_out    = busy;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected events are queued with their due cycle
// and matched against press_out/release_out every cycle.
module tb_input_conditioner;

  localparam logic [6:0] IDLE = 7'b0001111;

  typedef struct {
    int         cyc;
    logic [6:0] p;
    logic [6:0] r;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n;
  int   p;
  ev_t  sb[$];

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s @%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic push(input int c, input logic [6:0] pm, input logic [6:0] rm);
    ev_t e;
    e.cyc = c;
    e.p   = pm;
    e.r   = rm;
    sb.push_back(e);
  endtask

  // Scoreboard: an event due this cycle is popped; otherwise no event is allowed.
  always @(negedge clk) begin
    logic [6:0] ep;
    logic [6:0] er;
    ep = '0;
    er = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      ep = sb[0].p;
      er = sb[0].r;
      void'(sb.pop_front());
    end
    if (bus.press_out !== '0 || bus.release_out !== '0 || ep != '0 || er != '0) begin
      check("press_ev", bus.press_out, ep);
      check("release_ev", bus.release_out, er);
    end
  end

  initial begin
    bus.raw_in = IDLE;
    rst_n      = 1'b0;

    // reset state
    at_cycle(3);
    check("rst_level", bus.level_out, '0);
    check("rst_press", bus.press_out, '0);
    check("rst_release", bus.release_out, '0);
    check("rst_busy", bus.busy_out, '0);
    rst_n = 1'b1;
    at_cycle(8);
    check("idle_level", bus.level_out, '0);

    // 1: clean press/release on start
    bus.raw_in[6] = 1'b1;
    n = cyc;
    push(n + 6, 7'h40, 7'h00);
    at_cycle(n + 2);
    check("t1_busy_sync", bus.busy_out, 7'h00);
    at_cycle(n + 3);
    check("t1_busy_count", bus.busy_out, 7'h40);
    at_cycle(n + 5);
    check("t1_level_early", bus.level_out, 7'h00);
    at_cycle(n + 6);
    check("t1_level", bus.level_out, 7'h40);
    check("t1_busy_done", bus.busy_out, 7'h00);
    bus.raw_in[6] = 1'b0;
    n = cyc;
    push(n + 6, 7'h00, 7'h40);
    at_cycle(n + 6);
    check("t1_level_rel", bus.level_out, 7'h00);
    at_cycle(n + 8);

    // 2: bounce on mode, then steady high
    for (int k = 0; k < 10; k++) begin
      bus.raw_in[5] = 1'b1;
      at_cycle(cyc + 1);
      bus.raw_in[5] = 1'b0;
      at_cycle(cyc + 1);
    end
    check("t2_level_bounce", bus.level_out, 7'h00);
    bus.raw_in[5] = 1'b1;
    n = cyc;
    push(n + 6, 7'h20, 7'h00);
    at_cycle(n + 5);
    check("t2_level_early", bus.level_out, 7'h00);
    at_cycle(n + 6);
    check("t2_level", bus.level_out, 7'h20);
    bus.raw_in[5] = 1'b0;
    n = cyc;
    push(n + 6, 7'h00, 7'h20);
    at_cycle(n + 8);

    // 3: active-low button 0
    bus.raw_in[0] = 1'b0;
    n = cyc;
    push(n + 6, 7'h01, 7'h00);
    at_cycle(n + 6);
    check("t3_level", bus.level_out, 7'h01);
    bus.raw_in[0] = 1'b1;
    n = cyc;
    push(n + 6, 7'h00, 7'h01);
    at_cycle(n + 6);
    check("t3_level_rel", bus.level_out, 7'h00);
    at_cycle(n + 8);

    // 4: reset at count 2 on key_select
    bus.raw_in[4] = 1'b1;
    n = cyc;
    at_cycle(n + 4);
    check("t4_busy_pre", bus.busy_out, 7'h10);
    rst_n = 1'b0;
    at_cycle(n + 5);
    check("t4_level_rst", bus.level_out, '0);
    check("t4_busy_rst", bus.busy_out, '0);
    check("t4_press_rst", bus.press_out, '0);
    check("t4_release_rst", bus.release_out, '0);
    rst_n = 1'b1;
    push(n + 11, 7'h10, 7'h00);
    at_cycle(n + 10);
    check("t4_level_early", bus.level_out, 7'h00);
    at_cycle(n + 11);
    check("t4_level", bus.level_out, 7'h10);
    bus.raw_in[4] = 1'b0;
    n = cyc;
    push(n + 6, 7'h00, 7'h10);
    at_cycle(n + 8);

    // 5: buttons 3:0 and start together
    bus.raw_in = 7'b1000000;
    n = cyc;
    push(n + 6, 7'h4F, 7'h00);
    at_cycle(n + 6);
    check("t5_level", bus.level_out, 7'h4F);
    bus.raw_in = IDLE;
    n = cyc;
    push(n + 6, 7'h00, 7'h4F);
    at_cycle(n + 6);
    check("t5_level_rel", bus.level_out, 7'h00);
    at_cycle(n + 8);

    // 6: long hold on button 1, then on start
    bus.raw_in[1] = 1'b0;
    n = cyc;
    p = n + 6;
    push(p, 7'h02, 7'h00);
`ifdef INPUT_COND_AUTOREPEAT_EN
    push(p + 10, 7'h02, 7'h00);
    push(p + 13, 7'h02, 7'h00);
    push(p + 16, 7'h02, 7'h00);
    push(p + 19, 7'h02, 7'h00);
    push(p + 22, 7'h02, 7'h00);
`endif
    at_cycle(p + 17);
    check("t6_level_hold", bus.level_out, 7'h02);
    bus.raw_in[1] = 1'b1;
    push(p + 23, 7'h00, 7'h02);
    at_cycle(p + 25);
    check("t6_level_rel", bus.level_out, 7'h00);

    bus.raw_in[6] = 1'b1;
    n = cyc;
    push(n + 6, 7'h40, 7'h00);
    at_cycle(n + 26);
    check("t6_start_hold", bus.level_out, 7'h40);
    bus.raw_in[6] = 1'b0;
    n = cyc;
    push(n + 6, 7'h00, 7'h40);
    at_cycle(n + 10);

    total++;
    assert (sb.size() === 0) else begin
      bad++;
      $error("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the board's raw push-button and switch inputs before they reach the platform's PIO inputs. The inputs are buttons[3:0], key_select, mode and start. Each channel is synchronised, polarity-normalised and debounced. The block emits clean levels plus one-cycle press/release events. It sits between the FPGA pins and the `platform` PIO ports (`buttons_0_ext_export`, `key_select_0_ext_export`, `mode_0_ext_export`, `start_ext_export`).

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range ≥ 2.
- `INVERT_MASK`, default 7'b0001111: per-channel inversion; bit set means the pin is active-low.
- `REPEAT_MASK`, default 7'b0001111: channels eligible for auto-repeat (only with macro).
- `REPEAT_DELAY`, default 25_000_000: held cycles before first repeat event; ≥ 2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat events; ≥ 2.
- `clk_clk`  in  1  sole clock; all logic is on its rising edge.
- `reset_reset_n`  in  1  synchronous, active-low reset.
- `raw_in`  in  7  async pins. Bit map: [3:0] buttons, [4] key_select, [5] mode, [6] start.
- `level_out`  out  7  debounced, active-high levels (same bit map); to platform PIOs.
- `press_out`  out  7  one-cycle pulse per accepted 0→1 transition (plus repeats).
- `release_out`  out  7  one-cycle pulse per accepted 1→0 transition.
- `busy_out`  out  7  per-channel: debounce counter nonzero (change pending).

## Operation
Each channel is independent and identical.

- **Normalise:** `n = raw_in[i] ^ INVERT_MASK[i]`, so idle is 0.
- **Synchronise:** two-flop chain `s1 → s2`. Only `s2` is used downstream.
- **Debounce:** counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)` and registered `stable`.
  - If `s2 == stable`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch back to `stable` at any count restarts the count from 0; partial counts are never retained.
- **Level:** `level_out[i] = stable`.
- **Events:** registered together with the `stable` update.
  - `press_out[i]` = 1 in the cycle `stable` becomes 1.
  - `release_out[i]` = 1 in the cycle `stable` becomes 0.
  - Press and release are never both 1 on the same channel.
- **Busy:** `busy_out[i] = (cnt != 0)`, combinational from the register.
- **Reset:** while `reset_reset_n == 0` at a clock edge:
  - `s1`, `s2`, `stable`, `cnt` and the repeat counter clear to 0.
  - All outputs are 0 in the following cycle.
  - A button held through reset produces a press event `DEBOUNCE_CYCLES+2` cycles after reset deasserts.

## Timing
- Pin change (held steady) → `level_out` changes after exactly `DEBOUNCE_CYCLES+2` rising edges: 2 for sync, `DEBOUNCE_CYCLES` for debounce.
- `press_out` / `release_out` are high for exactly one cycle, coincident with the `level_out` edge.
- The minimum spacing between two accepted transitions on one channel is `DEBOUNCE_CYCLES` cycles.
- Simultaneous changes on several channels are handled independently. Multiple event bits may be high in the same cycle.
- Reset asserted mid-count discards the pending change; no event fires.

## Configuration
- Macro: `INPUT_COND_AUTOREPEAT_EN`.
- **Defined:** channels with `REPEAT_MASK[i]=1` get a repeat counter `rc`.
  - While `stable == 1`, `rc` counts from the press.
  - Extra `press_out` pulses fire at `REPEAT_DELAY` cycles after the press, then every `REPEAT_PERIOD` cycles after that.
  - `rc` clears on release or reset.
  - `release_out` is unaffected.
- **Undefined:** no repeat logic is generated and `press_out` fires once per accepted press. Parameters `REPEAT_*` are ignored.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`, default masks.

1. **Clean press.** Drive `raw_in[6]` 0→1 and hold → `level_out[6]` rises and `press_out[6]=1` for one cycle, exactly 6 edges later. `busy_out[6]` is high during the count.
2. **Bounce rejection.** Toggle `raw_in[5]` 1 cycle high / 1 low, 10 times, then hold high → no event during the bounce. Press fires 6 cycles after the final steady edge.
3. **Active-low button.** Drive `raw_in[0]` 1→0 (pressed) → `press_out[0]` after 6 cycles. Returning to 1 gives `release_out[0]` 6 cycles later.
4. **Reset mid-operation.** Start a change on `raw_in[4]`, assert `reset_reset_n=0` at count 2 for 1 cycle, keep the pin held → all outputs 0 the cycle after reset. Press arrives 6 cycles after reset deasserts.
5. **Simultaneous channels.** Change `raw_in[3:0]` and `raw_in[6]` on the same edge → 5 press bits are high in the same cycle.
6. **Auto-repeat** (macro defined). Hold button 1 → press pulses at 0, +10, +13, +16 cycles relative to the first press. Holding `raw_in[6]` (not in `REPEAT_MASK`) yields a single pulse. With the macro undefined, button 1 also yields a single pulse.
